// File: rtl/vga_mem_arbiter_if.sv
// Bundle of the VGA fetch port, the bus master port, the starve flag and the
// single-port memory port around vga_mem_arbiter.
interface vga_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  vga_req_i;
    logic [ADDR_WIDTH-1:0] vga_addr_i;
    logic                  vga_rvalid_o;
    logic [DATA_WIDTH-1:0] vga_rdata_o;

    logic                  bus_req_i;
    logic                  bus_we_i;
    logic [ADDR_WIDTH-1:0] bus_addr_i;
    logic [DATA_WIDTH-1:0] bus_wdata_i;
    logic                  bus_gnt_o;
    logic                  bus_rvalid_o;
    logic [DATA_WIDTH-1:0] bus_rdata_o;

    logic                  starve_clr_i;
    logic                  starve_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    // Arbiter side
    modport slave (
        input  vga_req_i, vga_addr_i,
        input  bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i,
        input  starve_clr_i, mem_rdata_i,
        output vga_rvalid_o, vga_rdata_o,
        output bus_gnt_o, bus_rvalid_o, bus_rdata_o,
        output starve_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    // Requester / memory side
    modport master (
        output vga_req_i, vga_addr_i,
        output bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i,
        output starve_clr_i, mem_rdata_i,
        input  vga_rvalid_o, vga_rdata_o,
        input  bus_gnt_o, bus_rvalid_o, bus_rdata_o,
        input  starve_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-port character/attribute memory arbiter: VGA fetches have strict
// priority, the bus master uses idle slots. A tag shift pipeline matching the
// memory read latency steers each response to its requester, and a saturating
// counter flags sustained bus starvation.
module vga_mem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk_i,
    input  logic              arst_i,
    vga_mem_arbiter_if.slave  arb
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C    = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1_C = CNT_W'(STARVE_LIMIT - 1);

    logic                    gnt;
    logic                    denied;
    logic [READ_LATENCY-1:0] vga_tag;
    logic [READ_LATENCY-1:0] bus_tag;
    logic [CNT_W-1:0]        starve_cnt;
    logic                    starve_q;
    logic                    vga_rvalid;
    logic                    bus_rvalid;

    // Bus is granted only in slots VGA leaves free, never during reset
    always_comb begin
        gnt    = arb.bus_req_i & ~arb.vga_req_i & ~arst_i;
        denied = arb.bus_req_i & ~gnt;
    end

    // Memory port mux: VGA first, then granted bus access, otherwise idle zeros
    always_comb begin
        arb.mem_en_o    = 1'b0;
        arb.mem_we_o    = 1'b0;
        arb.mem_addr_o  = '0;
        arb.mem_wdata_o = '0;
        if (!arst_i && arb.vga_req_i) begin
            arb.mem_en_o   = 1'b1;
            arb.mem_addr_o = arb.vga_addr_i;
        end else if (gnt) begin
            arb.mem_en_o   = 1'b1;
            arb.mem_we_o   = arb.bus_we_i;
            arb.mem_addr_o = arb.bus_addr_i;
            if (arb.bus_we_i) begin
                arb.mem_wdata_o = arb.bus_wdata_i;
            end
        end
    end

    // Read tag shift pipeline; stage READ_LATENCY-1 lines up with mem_rdata_i
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            vga_tag <= '0;
            bus_tag <= '0;
        end else begin
            vga_tag[0] <= arb.vga_req_i;
            bus_tag[0] <= gnt & ~arb.bus_we_i;
            for (int unsigned s = 1; s < READ_LATENCY; s++) begin
                vga_tag[s] <= vga_tag[s-1];
                bus_tag[s] <= bus_tag[s-1];
            end
        end
    end

    // Response steering; data is zeroed whenever its valid is low
    always_comb begin
        vga_rvalid       = vga_tag[READ_LATENCY-1];
        bus_rvalid       = bus_tag[READ_LATENCY-1];
        arb.vga_rvalid_o = vga_rvalid;
        arb.bus_rvalid_o = bus_rvalid;
        arb.vga_rdata_o  = vga_rvalid ? arb.mem_rdata_i : '0;
        arb.bus_rdata_o  = bus_rvalid ? arb.mem_rdata_i : '0;
        arb.bus_gnt_o    = gnt;
        arb.starve_o     = starve_q;
    end

    // Starvation tracking: the flag sets on the edge the count reaches the
    // limit (winning over a simultaneous clear) and holds until cleared
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            starve_cnt <= '0;
            starve_q   <= 1'b0;
        end else begin
            if (denied) begin
                if (starve_cnt != LIMIT_C) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end

            if (denied && starve_cnt == LIMIT_M1_C) begin
                starve_q <= 1'b1;
            end else if (arb.starve_clr_i) begin
                starve_q <= 1'b0;
            end
        end
    end

endmodule
